// File: rtl/eyeriss_pkg.sv
// -----------------------------------------------------------------------------
// eyeriss_pkg
// Definitions shared by the GLB -> spad loader, the GLB memory_bank and the
// pe_spad blocks:
//   - default geometry: GLB address/data widths, spad address width,
//     lanes per PE row and the width of one lane
//   - loader_state_t : state encoding of the glb_spad_loader FSM
// -----------------------------------------------------------------------------
package eyeriss_pkg;

  localparam int GLB_ADDR_BITS  = 8;
  localparam int GLB_DATA_BITS  = 6;
  localparam int SPAD_ADDR_BITS = 3;
  localparam int LANES          = 3;
  localparam int LANE_BITS      = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/glb_spad_loader_if.sv
// -----------------------------------------------------------------------------
// glb_spad_loader_if
// Bus between the loader, the GLB memory_bank read port and one PE spad row.
//   glb_addr         : GLB read address (loader -> GLB)
//   glb_write_enable : GLB write strobe, always 0 from the loader
//   glb_data_out     : GLB registered read data, one cycle after glb_addr
//   out_valid        : spad write offered (loader -> spad row)
//   out_ready        : spad row can accept (spad row -> loader)
//   spad_addr        : spad write address
//   spad_data        : lane i on bits [i*LANE_BITS +: LANE_BITS]
//   spad_we          : per-lane write enable, all ones while out_valid
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid is raised it stays high, and spad_addr /
// spad_data / spad_we stay stable, until that edge. out_ready may change
// freely and never feeds back combinationally into any loader output.
//
// Modports: master = loader side, slave = GLB + spad row side.
// -----------------------------------------------------------------------------
interface glb_spad_loader_if #(
  parameter int GLB_ADDR_BITS  = eyeriss_pkg::GLB_ADDR_BITS,
  parameter int GLB_DATA_BITS  = eyeriss_pkg::GLB_DATA_BITS,
  parameter int SPAD_ADDR_BITS = eyeriss_pkg::SPAD_ADDR_BITS,
  parameter int LANES          = eyeriss_pkg::LANES
);

  logic [GLB_ADDR_BITS-1:0]  glb_addr;
  logic                      glb_write_enable;
  logic [GLB_DATA_BITS-1:0]  glb_data_out;
  logic                      out_valid;
  logic                      out_ready;
  logic [SPAD_ADDR_BITS-1:0] spad_addr;
  logic [GLB_DATA_BITS-1:0]  spad_data;
  logic [LANES-1:0]          spad_we;

  modport master (
    output glb_addr, glb_write_enable, out_valid, spad_addr, spad_data, spad_we,
    input  glb_data_out, out_ready
  );

  modport slave (
    input  glb_addr, glb_write_enable, out_valid, spad_addr, spad_data, spad_we,
    output glb_data_out, out_ready
  );

endinterface

// File: rtl/glb_addr_gen.sv
// -----------------------------------------------------------------------------
// glb_addr_gen
// Holds the command base address, word index and word count, and produces the
// registered GLB read address base+idx (wrapping modulo 2^ADDR_BITS) plus the
// "current word is the last one" flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : capture i_base / i_len, clear idx, address <= base
//   i_base       : command base address
//   i_len        : saturated word count
//   i_advance    : move to the next word (idx+1, address+1 with wrap)
//   o_addr       : registered GLB read address
//   o_last       : idx+1 == len
// -----------------------------------------------------------------------------
module glb_addr_gen #(
  parameter int ADDR_BITS = 8,
  parameter int CNT_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [ADDR_BITS-1:0] i_base,
  input  logic [CNT_BITS-1:0]  i_len,
  input  logic                 i_advance,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic                 o_last
);

  logic [ADDR_BITS-1:0] r_base;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CNT_BITS-1:0]  r_idx;
  logic [CNT_BITS-1:0]  r_len;
  logic [CNT_BITS-1:0]  w_idx_next;

  assign w_idx_next = r_idx + CNT_BITS'(1);
  assign o_last     = (w_idx_next == r_len);
  assign o_addr     = r_addr;

  // The address is recomputed from base+idx rather than incremented so the
  // register always equals the architectural base+idx; the carry out of the
  // top bit is dropped, giving the 255 -> 0 wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= '0;
      r_addr <= '0;
      r_idx  <= '0;
      r_len  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_len  <= i_len;
      r_idx  <= '0;
      r_addr <= i_base;
    end else if (i_advance) begin
      r_idx  <= w_idx_next;
      r_addr <= r_base + ADDR_BITS'(w_idx_next);
    end
  end

endmodule

// File: rtl/glb_spad_loader.sv
// -----------------------------------------------------------------------------
// glb_spad_loader
// Read-side DMA from the global buffer into one row of PE scratchpads. A start
// command reads len contiguous GLB words from base_addr and writes each word to
// the spad row (LANES lanes of LANE_BITS) at consecutive spad addresses,
// honouring a valid/ready handshake towards the spads.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : command strobe, only looked at in IDLE
//   base_addr    : first GLB address, captured on an accepted start
//   len          : word count, values above 2^SPAD_ADDR_BITS saturate
//   busy         : high from the accepted start until done
//   done         : one-cycle completion pulse
//   wr_count     : words pushed by the last command, held until next start
//   dbg_state    : current FSM state, for observation only
//   bus          : GLB read port + spad write port (glb_spad_loader_if.master)
//
// Build option: define GLB_LOADER_ZERO_SKIP_EN to drop all-zero GLB words
// instead of pushing them; idx still advances but the spad pointer and
// wr_count do not.
//
// Every output comes from a flop; out_ready only steers next-state logic.
// -----------------------------------------------------------------------------
module glb_spad_loader
  import eyeriss_pkg::*;
#(
  parameter int GLB_ADDR_BITS  = eyeriss_pkg::GLB_ADDR_BITS,
  parameter int GLB_DATA_BITS  = eyeriss_pkg::GLB_DATA_BITS,
  parameter int SPAD_ADDR_BITS = eyeriss_pkg::SPAD_ADDR_BITS,
  parameter int LANES          = eyeriss_pkg::LANES,
  parameter int LANE_BITS      = eyeriss_pkg::LANE_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [GLB_ADDR_BITS-1:0]  base_addr,
  input  logic [SPAD_ADDR_BITS:0]   len,
  output logic                      busy,
  output logic                      done,
  output logic [SPAD_ADDR_BITS:0]   wr_count,
  output loader_state_t             dbg_state,
  glb_spad_loader_if.master         bus
);

  localparam int CNT_W = SPAD_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(2 ** SPAD_ADDR_BITS);

  loader_state_t r_state;
  loader_state_t w_state_next;

  logic                      w_start_acc;
  logic                      w_load;
  logic                      w_advance;
  logic                      w_capture;
  logic                      w_hs;
  logic                      w_last;
  logic [CNT_W-1:0]          w_len_sat;
  logic [GLB_ADDR_BITS-1:0]  w_glb_addr;

  logic                      r_busy;
  logic                      r_done;
  logic                      r_out_valid;
  logic [LANES-1:0]          r_spad_we;
  logic [GLB_DATA_BITS-1:0]  r_data_q;
  logic [SPAD_ADDR_BITS-1:0] r_ptr;
  logic [CNT_W-1:0]          r_wr_count;

  // A spad row only holds 2^SPAD_ADDR_BITS words, so longer requests clip.
  assign w_len_sat = (len > MAX_LEN) ? MAX_LEN : len;

  glb_addr_gen #(
    .ADDR_BITS (GLB_ADDR_BITS),
    .CNT_BITS  (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_base    (base_addr),
    .i_len     (w_len_sat),
    .i_advance (w_advance),
    .o_addr    (w_glb_addr),
    .o_last    (w_last)
  );

  // Next-state and strobe decode
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          if (w_len_sat != '0) begin
            w_load       = 1'b1;
            w_state_next = ST_REQ;
          end else begin
            // Empty command: report completion with wr_count = 0.
            w_state_next = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // GLB read data for the address issued in REQ is valid this cycle.
        w_capture = 1'b1;
`ifdef GLB_LOADER_ZERO_SKIP_EN
        if (bus.glb_data_out == '0) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? ST_DONE : ST_REQ;
        end else begin
          w_state_next = ST_PUSH;
        end
`else
        w_state_next = ST_PUSH;
`endif
      end
      ST_PUSH: begin
        if (bus.out_ready) begin
          w_hs         = 1'b1;
          w_advance    = 1'b1;
          w_state_next = w_last ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs. Status outputs are decoded from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_spad_we   <= '0;
      r_data_q    <= '0;
      r_ptr       <= '0;
      r_wr_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= (w_state_next == ST_REQ) || (w_state_next == ST_WAIT) ||
                     (w_state_next == ST_PUSH);
      r_done      <= (w_state_next == ST_DONE);
      r_out_valid <= (w_state_next == ST_PUSH);
      r_spad_we   <= {LANES{w_state_next == ST_PUSH}};
      if (w_capture) begin
        r_data_q <= bus.glb_data_out;
      end
      if (w_start_acc) begin
        r_ptr      <= '0;
        r_wr_count <= '0;
      end else if (w_hs) begin
        r_ptr      <= r_ptr + SPAD_ADDR_BITS'(1);
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  // Lane i of the row takes bits [i*LANE_BITS +: LANE_BITS] of the GLB word.
  always_comb begin
    bus.spad_data = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.spad_data[i*LANE_BITS +: LANE_BITS] = r_data_q[i*LANE_BITS +: LANE_BITS];
    end
  end

  assign bus.glb_addr         = w_glb_addr;
  assign bus.glb_write_enable = 1'b0;
  assign bus.out_valid        = r_out_valid;
  assign bus.spad_addr        = r_ptr;
  assign bus.spad_we          = r_spad_we;

  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_count  = r_wr_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_glb_spad_loader.sv
// -----------------------------------------------------------------------------
// tb_glb_spad_loader
// Bench for glb_spad_loader: GLB memory model with one-cycle registered read,
// scripted/random out_ready, a cycle-timing reference model built from the
// command timing rules, directed cases with literal expectations and a
// randomized command loop. Honours GLB_LOADER_ZERO_SKIP_EN when defined.
// -----------------------------------------------------------------------------
module tb_glb_spad_loader;
  import eyeriss_pkg::*;

`ifdef GLB_LOADER_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [3:0] len = '0;
  logic       busy;
  logic       done;
  logic [3:0] wr_count;
  loader_state_t dbg_state;

  glb_spad_loader_if bus ();

  glb_spad_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // GLB: registered read, one cycle latency
  logic [5:0] mem [256];
  always @(posedge clk) bus.glb_data_out <= mem[bus.glb_addr];

  // ---------------- counters / check ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- out_ready driver ----------------
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stall word 1 four cycles
  int stall_used = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.out_valid && bus.spad_addr == 3'd1 && stall_used < 4) begin
            bus.out_ready = 1'b0;
            stall_used++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- reference model + compare ----------------
  function automatic int sat_len(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  logic [8:0] exp_q[$];        // {spad_addr, data} of each expected push
  int         hs_rel[$];       // handshake edge, relative to accept edge E0
  logic [8:0] hs_val[$];
  logic [7:0] req_log[$];      // glb_addr seen in each request cycle
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_rel = -1;
  bit  m_active = 0;
  bit  m_pending = 0;
  int  m_e0 = 0, m_req_t = 0, m_valid_t = 0, m_done_t = -1;
  int  m_idx = 0, m_n = 0;
  logic [7:0] m_base = '0;
  logic [3:0] m_wr = '0;

  always @(negedge clk) begin
    logic [7:0] a;
    logic [5:0] w;
    logic [2:0] p;
    bit ev;
    cyc++;
    if (!reset_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_glb_addr", bus.glb_addr, 0);
      m_active = 0; m_pending = 0; m_done_t = -1; m_wr = '0;
      exp_q.delete();
    end else begin
      if (cyc == m_done_t) m_active = 0;
      if (m_active && !m_pending && cyc == m_req_t) begin
        a = m_base + 8'(m_idx);
        req_log.push_back(bus.glb_addr);
        chk("glb_addr", bus.glb_addr, a);
        w = mem[a];
        if (ZS && w == 6'd0) begin
          m_idx++;
          if (m_idx == m_n) m_done_t = cyc + 2;
          else m_req_t = cyc + 2;
        end else begin
          m_pending = 1;
          m_valid_t = cyc + 2;
        end
      end
      ev = m_active && m_pending && (cyc >= m_valid_t);
      chk("out_valid", bus.out_valid, ev);
      chk("spad_we", bus.spad_we, ev ? 3'b111 : 3'b000);
      chk("busy", busy, m_active);
      chk("done", done, (cyc == m_done_t));
      chk("wr_count", wr_count, m_wr);
      chk("glb_we", bus.glb_write_enable, 0);
      if (ev) begin
        if (exp_q.size() == 0) chk("push_unexpected", 1, 0);
        else chk("push_word", {bus.spad_addr, bus.spad_data}, exp_q[0]);
      end
      if (cyc == m_done_t) begin
        done_cnt++;
        done_rel = cyc - m_e0;
      end
      if (ev && bus.out_ready) begin
        hs_rel.push_back(cyc + 1 - m_e0);
        hs_val.push_back({bus.spad_addr, bus.spad_data});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_wr++;
        m_pending = 0;
        m_idx++;
        if (m_idx == m_n) m_done_t = cyc + 1;
        else m_req_t = cyc + 1;
      end
      if (start && !m_active && cyc != m_done_t) begin
        m_e0 = cyc + 1;
        m_base = base_addr;
        m_n = sat_len(len);
        m_idx = 0;
        m_wr = '0;
        exp_q.delete();
        p = '0;
        for (int k = 0; k < m_n; k++) begin
          a = base_addr + 8'(k);
          if (!(ZS && mem[a] == 6'd0)) begin
            exp_q.push_back({p, mem[a]});
            p++;
          end
        end
        if (m_n == 0) m_done_t = cyc + 1;
        else begin
          m_active = 1;
          m_req_t = cyc + 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", (done_cnt != d0), 1);
  endtask

  task automatic run_cmd(input logic [7:0] b, input logic [3:0] l, input bit stray);
    int d0;
    hs_rel.delete(); hs_val.delete(); req_log.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    if (stray) begin
      // Lands while the command is in WAIT; must be dropped.
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'($urandom); len = 4'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(d0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_we"}, bus.spad_we, 0);
    chk({tag, "_wr"}, wr_count, 0);
    chk({tag, "_gaddr"}, bus.glb_addr, 0);
    chk({tag, "_saddr"}, bus.spad_addr, 0);
    chk({tag, "_sdata"}, bus.spad_data, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, n;
    logic [3:0] rl;
    for (int i = 0; i < 256; i++) mem[i] = 6'($urandom_range(1, 63));
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;

    // 1: three words, always ready
    mem[8'h10] = 6'h3F; mem[8'h11] = 6'h15; mem[8'h12] = 6'h2A;
    run_cmd(8'h10, 4'd3, 0);
    chk("t1_n", hs_rel.size(), 3);
    if (hs_rel.size() == 3) begin
      chk("t1_hs0", hs_rel[0], 3);
      chk("t1_hs1", hs_rel[1], 6);
      chk("t1_hs2", hs_rel[2], 9);
      chk("t1_w0", hs_val[0], {3'd0, 6'h3F});
      chk("t1_w1", hs_val[1], {3'd1, 6'h15});
      chk("t1_w2", hs_val[2], {3'd2, 6'h2A});
    end
    chk("t1_done", done_rel, 9);
    chk("t1_wr", wr_count, 3);

    // 2: same with a four-cycle stall on word 1
    ready_mode = 2; stall_used = 0;
    run_cmd(8'h10, 4'd3, 0);
    ready_mode = 0;
    chk("t2_n", hs_rel.size(), 3);
    if (hs_rel.size() == 3) begin
      chk("t2_hs1", hs_rel[1], 10);
      chk("t2_w1", hs_val[1], {3'd1, 6'h15});
    end
    chk("t2_done", done_rel, 13);
    chk("t2_wr", wr_count, 3);

    // 3: address wrap
    mem[8'hFE] = 6'h01; mem[8'hFF] = 6'h02; mem[8'h00] = 6'h03; mem[8'h01] = 6'h04;
    run_cmd(8'hFE, 4'd4, 0);
    chk("t3_nreq", req_log.size(), 4);
    if (req_log.size() == 4) begin
      chk("t3_a0", req_log[0], 8'hFE);
      chk("t3_a1", req_log[1], 8'hFF);
      chk("t3_a2", req_log[2], 8'h00);
      chk("t3_a3", req_log[3], 8'h01);
    end
    chk("t3_wr", wr_count, 4);

    // 4: len=0 and saturation
    run_cmd(8'h20, 4'd0, 0);
    chk("t4_done", done_rel, 0);
    chk("t4_n", hs_rel.size(), 0);
    chk("t4_wr", wr_count, 0);
    run_cmd(8'h50, 4'd12, 0);
    chk("t4_sat_n", hs_rel.size(), 8);
    chk("t4_sat_wr", wr_count, 8);

    // 5: reset in the middle of word 2, then a clean command
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h60; len = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (wr_count != 4'd2 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("t5_reach_w2", wr_count, 2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_no_done", done_cnt, d0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_cmd(8'h70, 4'd3, 0);
    chk("t5_n", hs_rel.size(), 3);
    if (hs_rel.size() == 3) chk("t5_addr0", hs_val[0][8:6], 0);
    chk("t5_wr", wr_count, 3);

    // 6: a zero word in the middle
    mem[8'h40] = 6'h05; mem[8'h41] = 6'h00; mem[8'h42] = 6'h07;
    run_cmd(8'h40, 4'd3, 0);
    chk("t6_n", hs_rel.size(), ZS ? 2 : 3);
    chk("t6_wr", wr_count, ZS ? 2 : 3);
    if (hs_rel.size() >= 2) chk("t6_w1", hs_val[1], ZS ? {3'd1, 6'h07} : {3'd1, 6'h00});

    // randomized commands
    ready_mode = 1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      rl = 4'($urandom_range(0, 15));
      run_cmd(8'($urandom), rl, (sat_len(rl) >= 1) && ($urandom_range(0, 1) == 1));
    end
    ready_mode = 0;

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
